// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU types for the pipeline sequencer: hazard FSM states, register-select type,
// and the width of the optional performance counters.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned PERF_CNT_W = 32;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an EX-stage load whose destination feeds an ID-stage source.
// Purely combinational so forwarding logic can reuse it.
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGW = REG_W
) (
  input  logic            ex_dREN,
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  output logic            lu_hazard
);

  // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    lu_hazard = ex_dREN && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: per-latch enable/flush and PC enable from memory waits, load-use,
// redirect and halt. Define HAZARD_PERF_EN to build the stall/flush/wait counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGW = REG_W,
  parameter int unsigned CNTW = PERF_CNT_W
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            mem_halt,
  input  logic            ex_dREN,
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ex_redirect,
  output logic            pc_en,
  output logic            en_ifid,
  output logic            en_idex,
  output logic            en_exmem,
  output logic            en_memwb,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic            halt,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0] wait_cnt
);

  hz_state_t state;
  logic      memop;
  logic      adv;
  logic      lu_hazard;
  logic      lu_bubble;
  logic      redirect;

  hazard_detect #(.REGW(REGW)) u_detect (
    .ex_dREN   (ex_dREN),
    .ex_rd     (ex_rd),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .lu_hazard (lu_hazard)
  );

  always_comb begin
    memop = mem_dREN | mem_dWEN;
    unique case (state)
      RUN:      adv = memop ? dhit : ihit;
      MEM_WAIT: adv = dhit;
      default:  adv = 1'b0;
    endcase

    pc_en       = adv;
    en_ifid     = adv;
    en_idex     = adv;
    en_exmem    = adv;
    en_memwb    = adv;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    lu_bubble   = 1'b0;
    redirect    = 1'b0;

    // Redirect squashes the stalled ID instruction, so it outranks load-use; load-use must
    // hold IF/ID, so it outranks the fetch-retry bubble.
    if (adv) begin
      if (ex_redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        redirect   = 1'b1;
      end else if (lu_hazard) begin
        pc_en      = 1'b0;
        en_ifid    = 1'b0;
        flush_idex = 1'b1;
        lu_bubble  = 1'b1;
      end else if (memop && !ihit) begin
        flush_ifid = 1'b1;
        pc_en      = 1'b0;
      end
      if (mem_halt) flush_exmem = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (adv && mem_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (memop && !dhit) begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (adv && mem_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (dhit) begin
            state <= RUN;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else if (state != HALTED) begin
      if ((!adv || lu_bubble) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1))            flush_cnt <= flush_cnt + 1'b1;
      if ((state == MEM_WAIT) && (wait_cnt != '1))  wait_cnt  <= wait_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline.
- Generates per-latch enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB (the write-back latch), plus PC enable.
- Arbitrates between instruction-fetch wait, data-memory wait, load-use hazard, control redirect and halt.
- Sits beside the datapath; every stage latch uses its en_*/flush_* pair in place of raw ihit/flush.

Parameters:
- REGW, 5, register-select width (rs/rt/rd).
- CNTW, 32, width of optional performance counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  imem returned instruction this cycle
- dhit  in  1  dmem completed access this cycle
- mem_dREN  in  1  MEM-stage instruction reads dmem
- mem_dWEN  in  1  MEM-stage instruction writes dmem
- mem_halt  in  1  MEM-stage instruction is HALT
- ex_dREN  in  1  EX-stage instruction is a load
- ex_rd  in  REGW  EX-stage destination register
- id_rs, id_rt  in  REGW  ID-stage source registers
- ex_redirect  in  1  branch taken / jump resolved in EX
- pc_en  out  1  PC may update
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  latch load enables
- flush_ifid, flush_idex, flush_exmem  out  1 each  latch loads bubble (wins over en)
- halt  out  1  sticky processor halted
- stall_cnt, flush_cnt, wait_cnt  out  CNTW each  perf counters

Behaviour:
- FSM states: RUN, MEM_WAIT, HALTED. Reset → RUN; halt=0; counters=0.
- Outputs are combinational from state and inputs. halt is registered.
- memop = mem_dREN | mem_dWEN.
- adv (pipeline advances) is:
  - RUN: memop ? dhit : ihit
  - MEM_WAIT: dhit
  - HALTED: 0
- RUN → MEM_WAIT when memop & ~dhit.
- MEM_WAIT → RUN on dhit. Single-cycle dhit in RUN needs no wait state.
- All en_* = adv. When adv=0: all flush_*=0 and pc_en=0.
- On an adv cycle with memop and ~ihit: flush_ifid=1, pc_en=0. Fetch is retried; IF inserts a bubble.
- Load-use: ex_dREN & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt). On adv:
  - pc_en=0, en_ifid=0 (IF/ID held)
  - flush_idex=1
  - EX/MEM and MEM/WB advance
- Redirect: ex_redirect on adv → flush_ifid=1, flush_idex=1, pc_en=1 (PC loads target).
- Priority: HALTED > memory wait > redirect > load-use > normal.
  - Redirect + load-use in the same cycle → redirect only; the stalled ID instruction is squashed.
- Halt: mem_halt on an adv cycle:
  - state → HALTED, halt ← 1 next edge
  - flush_exmem=1 that cycle, so nothing younger reaches MEM
  - HALTED persists until nRST. All en=0, pc_en=0, flushes=0.
- Async reset mid-MEM_WAIT returns to RUN immediately. Outstanding dhit after reset is ignored.
- ex_rd==0 never triggers load-use.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments each non-HALTED cycle where adv=0 or a load-use bubble is inserted.
  - flush_cnt increments per redirect.
  - wait_cnt increments per MEM_WAIT cycle.
  - All three saturate at all-ones and reset to 0.
- Undefined: counter ports driven constant 0; no counter flops synthesized.

Decomposition:
- Add to the shared CPU types package: hz_state_t enum {RUN, MEM_WAIT, HALTED}, regbits_t reuse, and the perf-counter width constant.
- One natural sub-module: hazard_detect, a purely combinational load-use comparator (ex_dREN, ex_rd, id_rs, id_rt → lu_hazard), reused later by forwarding.
- FSM and enable generation stay in hazard_ctrl.

Test Plan:
- Reset then ihit=1, no hazards → all en=1, flushes 0, pc_en=1 every cycle; halt=0.
- mem_dREN=1, dhit low for 3 cycles then high → 3 cycles all en=0 in MEM_WAIT (wait_cnt=3), 4th cycle all en=1, back to RUN.
- ex_dREN=1, ex_rd=5, id_rt=5, ihit=1 → pc_en=0, en_ifid=0, flush_idex=1, en_exmem=en_memwb=1. Repeat with ex_rd=0 → no stall.
- ex_redirect=1 together with the load-use condition → flush_ifid=flush_idex=1, pc_en=1, flush_cnt+1, no stall.
- mem_halt=1 with ihit=1 → flush_exmem=1 that cycle; next cycle halt=1, all en=0; stays halted until nRST pulse.
- nRST asserted during MEM_WAIT → state RUN, counters 0; dhit pulse afterward with memop=0 has no effect.
